// File: rtl/mac_adder_arbiter.sv
// Round-robin arbiter that shares a single 32-bit adder between NREQ requesters.
// The result register is a one-entry output stage with valid/ready and no drain bubble.

module adder_32bit (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);

   logic [32:0] full_sum;

   assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
   assign sum_o    = full_sum[31:0];
   assign cout_o   = full_sum[32];

endmodule

module mac_adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   input  logic [NREQ-1:0]    req_cin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_sum,
   output logic               rsp_cout,
   output logic [IDW-1:0]     rsp_id,
   output logic [CNTW-1:0]    op_count
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e          state_q;
   logic [IDW-1:0]  rr_ptr_q;
   logic [IDW-1:0]  rr_ptr_d;
   logic [31:0]     sum_q;
   logic            cout_q;
   logic [IDW-1:0]  id_q;
   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;

   logic [31:0]     lane_a   [NREQ];
   logic [31:0]     lane_b   [NREQ];
   logic [IDW-1:0]  grant;
   logic            can_accept;
   logic            accept;
   logic [31:0]     add_a;
   logic [31:0]     add_b;
   logic            add_cin;
   logic [31:0]     add_sum;
   logic            add_cout;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
         assign lane_a[gi]    = req_a[32*gi +: 32];
         assign lane_b[gi]    = req_b[32*gi +: 32];
         assign req_ready[gi] = accept & (grant == IDW'(gi));
      end
   endgenerate

   // Circular priority search starting at rr_ptr_q; the first valid lane wins.
   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && req_valid[idx]) begin
            grant = IDW'(idx);
            found = 1'b1;
         end
      end
   end

   // rst_n gates acceptance so no requester sees a handshake during reset.
   assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
   assign accept     = rst_n & can_accept & (|req_valid);

   assign add_a   = lane_a[grant];
   assign add_b   = lane_b[grant];
   assign add_cin = req_cin[grant];

   adder_32bit u_adder (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   assign rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
   assign cnt_d    = cnt_q + CNTW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         id_q     <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            state_q  <= ST_FULL;
            sum_q    <= add_sum;
            cout_q   <= add_cout;
            id_q     <= grant;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
         end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_q <= ST_EMPTY;
         end
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_id    = id_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_mac_adder_arbiter.sv
// Randomized and directed bench for mac_adder_arbiter against a cycle-level
// transaction model (circular search, one-entry result register, wrapping counter).

module tb_mac_adder_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 16;

   logic               clk;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]    req_cin;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_sum;
   logic               rsp_cout;
   logic [IDW-1:0]     rsp_id;
   logic [CNTW-1:0]    op_count;

   mac_adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   bit          m_valid;
   logic [31:0] m_sum;
   bit          m_cout;
   int          m_id;
   int          m_ptr;
   int          m_cnt;
   bit          verbose;
   logic [NREQ-1:0] obs_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_sum   = '0;
      m_cout  = 0;
      m_id    = 0;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock: check comb + registered outputs at negedge, then advance the model.
   task automatic step(input bit do_chk);
      int g;
      bit acc;
      logic [NREQ-1:0] exp_ready;
      logic [32:0] s;
      @(negedge clk);
      g   = model_grant(req_valid);
      acc = (!m_valid || rsp_ready) && (g >= 0);
      exp_ready = acc ? NREQ'(1 << g) : '0;
      obs_ready = req_ready;
      if (do_chk) begin
         chk("req_ready", 64'(req_ready), 64'(exp_ready));
         chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
         if (m_valid) begin
            chk("rsp_sum",  64'(rsp_sum),  64'(m_sum));
            chk("rsp_cout", 64'(rsp_cout), 64'(m_cout));
            chk("rsp_id",   64'(rsp_id),   64'(m_id));
         end
         chk("op_count", 64'(op_count), 64'(m_cnt));
      end
      @(posedge clk);
      if (acc) begin
         s = {1'b0, req_a[32*g +: 32]} + {1'b0, req_b[32*g +: 32]} + 33'(req_cin[g]);
         m_sum   = s[31:0];
         m_cout  = s[32];
         m_id    = g;
         m_valid = 1;
         m_ptr   = (g + 1) % NREQ;
         m_cnt   = (m_cnt + 1) % (1 << CNTW);
         if (verbose)
            $display("txn id=%0d a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d cnt=%0d",
                     g, req_a[32*g +: 32], req_b[32*g +: 32], req_cin[g], m_sum, m_cout, m_cnt);
      end else if (m_valid && rsp_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_cin[i]        = c;
   endtask

   initial begin
      int seq [6];
      logic [31:0] held_sum;
      seq = '{0, 1, 2, 3, 0, 1};
      verbose   = 1;
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_count", 64'(op_count), 64'd0);
      rst_n = 1'b1;

      // Carry out of the full-width add on requester 1
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      set_lane(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
      step(1);
      chk("t2_ready", 64'(obs_ready), 64'b0010);
      chk("t2_valid", 64'(rsp_valid), 64'd1);
      chk("t2_sum",   64'(rsp_sum),   64'd0);
      chk("t2_cout",  64'(rsp_cout),  64'd1);
      chk("t2_id",    64'(rsp_id),    64'd1);

      // Pointer at 2 with only lanes 0 and 3 requesting
      req_valid = 4'b1001;
      set_lane(3, 32'h7FFF_FFFF, 32'h0, 1'b1);
      set_lane(0, 32'd5, 32'd6, 1'b0);
      step(1);
      chk("t5_ready3", 64'(obs_ready), 64'b1000);
      chk("t5_sum",    64'(rsp_sum),   64'h8000_0000);
      chk("t5_cout",   64'(rsp_cout),  64'd0);
      chk("t5_id",     64'(rsp_id),    64'd3);
      req_valid = 4'b0001;
      step(1);
      chk("t5_ready0", 64'(obs_ready), 64'b0001);
      chk("t5_sum0",   64'(rsp_sum),   64'd11);

      // Backpressure: full register, consumer stalled
      req_valid = 4'b0110;
      rsp_ready = 1'b0;
      set_lane(1, 32'd1, 32'd2, 1'b0);
      held_sum = rsp_sum;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("t4_ready_stall", 64'(obs_ready), 64'd0);
         chk("t4_sum_held",    64'(rsp_sum),   64'(held_sum));
         chk("t4_valid_held",  64'(rsp_valid), 64'd1);
      end
      rsp_ready = 1'b1;
      step(1);
      chk("t4_ready_release", 64'(obs_ready), 64'b0010);
      chk("t4_sum_new",       64'(rsp_sum),   64'd3);

      // Asynchronous reset in the middle of traffic
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_lane(i, 32'(i * 16), 32'(i + 1), 1'b0);
      rst_n = 1'b0;
      #2;
      chk("t1_valid", 64'(rsp_valid), 64'd0);
      chk("t1_sum",   64'(rsp_sum),   64'd0);
      chk("t1_count", 64'(op_count),  64'd0);
      chk("t1_ready", 64'(req_ready), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Continuous round-robin with no drain bubble
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("t3_grant", 64'(obs_ready), 64'(1 << seq[i]));
         chk("t3_valid", 64'(rsp_valid), 64'd1);
      end

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) set_lane(i, $urandom, $urandom, 1'($urandom));
         step(1);
      end

      // Counter wrap after 65535 back-to-back accepts
      rst_n = 1'b0;
      #2;
      model_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      verbose   = 0;
      repeat (65535) step(0);
      chk("t6_count_max", 64'(op_count), 64'hFFFF);
      step(0);
      chk("t6_count_wrap", 64'(op_count), 64'd0);
      verbose = 1;
      step(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
